// File: rtl/cpu_phase_sequencer.sv
// rtl/cpu_phase_sequencer.sv - single-clock micro-sequencer for fetch/decode/uop/eip phases
//
// Purpose:
//   Steps the CPU datapath through fetch, decode, 1..MAX_UOPS micro-ops
//   (operand select, ALU, write-back) and an eip update. It issues exactly one
//   single-cycle strobe per cycle while an instruction is in flight.
//   Optional build macro SINGLE_STEP_EN adds a step input and a PAUSE state
//   that is entered after every instruction.
//
// Ports:
//   clk          rising-edge system clock
//   reset        synchronous, active-high reset
//   run          level; allows a new instruction to start
//   halt_req     halt request, latched and honoured at the next instruction boundary
//   step         (SINGLE_STEP_EN only) releases PAUSE into the next fetch
//   mem_ready    instruction memory has a valid opcode this cycle
//   num_of_ope   micro-op count from decode, sampled in the first SEL cycle
//   fetch_en     fetch strobe, held until mem_ready
//   decode_en    decode strobe
//   sel_en       one-hot operand-select strobe for micro-op k
//   alu_en       one-hot ALU strobe for micro-op k
//   wb_en        one-hot write-back strobe for micro-op k
//   eip_en       eip advance strobe
//   busy         an instruction is in flight
//   halted       sequencer is in HALT
//   bad_ope      sticky flag: num_of_ope was 0 or above MAX_UOPS
//   instr_count  retired-instruction counter, wraps

module cpu_phase_sequencer #(
    parameter int MAX_UOPS = 3,
    parameter int COUNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                halt_req,
`ifdef SINGLE_STEP_EN
    input  logic                step,
`endif
    input  logic                mem_ready,
    input  logic [3:0]          num_of_ope,
    output logic                fetch_en,
    output logic                decode_en,
    output logic [MAX_UOPS-1:0] sel_en,
    output logic [MAX_UOPS-1:0] alu_en,
    output logic [MAX_UOPS-1:0] wb_en,
    output logic                eip_en,
    output logic                busy,
    output logic                halted,
    output logic                bad_ope,
    output logic [COUNT_W-1:0]  instr_count
);

    localparam int IDX_W = (MAX_UOPS > 1) ? $clog2(MAX_UOPS) : 1;
    localparam logic [MAX_UOPS-1:0] UOP_ONE = MAX_UOPS'(1);
    localparam logic [IDX_W-1:0]    IDX_MAX = IDX_W'(MAX_UOPS - 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_SEL    = 4'd3,
        S_EXEC   = 4'd4,
        S_WB     = 4'd5,
        S_EIP    = 4'd6,
        S_HALT   = 4'd7
`ifdef SINGLE_STEP_EN
        ,
        S_PAUSE  = 4'd8
`endif
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [IDX_W-1:0] uop_idx;
    logic [IDX_W-1:0] uop_last;
    logic             halt_latch;

    logic             halt_pending;
    logic             last_uop;
    logic             latch_total;
    logic [IDX_W-1:0] ope_last;
    logic             ope_bad;

    // A halt_req arriving in the very cycle of a boundary decision still counts.
    assign halt_pending = halt_latch | halt_req;
    assign last_uop     = (uop_idx == uop_last);
    // num_of_ope is sampled only once per instruction: first SEL cycle.
    assign latch_total  = (state == S_SEL) && (uop_idx == '0);

    // Clamp the decoded count into 1..MAX_UOPS, stored as the index of the last micro-op.
    always_comb begin
        ope_bad  = 1'b0;
        ope_last = '0;
        if (num_of_ope == 4'd0) begin
            ope_bad  = 1'b1;
            ope_last = '0;
        end else if (32'(num_of_ope) > MAX_UOPS) begin
            ope_bad  = 1'b1;
            ope_last = IDX_MAX;
        end else begin
            ope_last = IDX_W'(num_of_ope - 4'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        fetch_en   = 1'b0;
        decode_en  = 1'b0;
        sel_en     = '0;
        alu_en     = '0;
        wb_en      = '0;
        eip_en     = 1'b0;
        busy       = 1'b0;
        halted     = 1'b0;

        case (state)
            S_IDLE: begin
                if (halt_pending) begin
                    state_next = S_HALT;
                end else if (run) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                fetch_en = 1'b1;
                busy     = 1'b1;
                if (mem_ready) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                decode_en  = 1'b1;
                busy       = 1'b1;
                state_next = S_SEL;
            end
            S_SEL: begin
                sel_en     = UOP_ONE << uop_idx;
                busy       = 1'b1;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                alu_en     = UOP_ONE << uop_idx;
                busy       = 1'b1;
                state_next = S_WB;
            end
            S_WB: begin
                wb_en      = UOP_ONE << uop_idx;
                busy       = 1'b1;
                state_next = last_uop ? S_EIP : S_SEL;
            end
            S_EIP: begin
                eip_en = 1'b1;
                busy   = 1'b1;
                if (halt_pending) begin
                    state_next = S_HALT;
                end else begin
`ifdef SINGLE_STEP_EN
                    state_next = S_PAUSE;
`else
                    state_next = run ? S_FETCH : S_IDLE;
`endif
                end
            end
`ifdef SINGLE_STEP_EN
            S_PAUSE: begin
                if (halt_pending) begin
                    state_next = S_HALT;
                end else if (step && run) begin
                    state_next = S_FETCH;
                end
            end
`endif
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            uop_idx     <= '0;
            uop_last    <= '0;
            halt_latch  <= 1'b0;
            bad_ope     <= 1'b0;
            instr_count <= '0;
        end else begin
            if (halt_req) begin
                halt_latch <= 1'b1;
            end
            if (state == S_DECODE) begin
                uop_idx <= '0;
            end else if ((state == S_WB) && !last_uop) begin
                uop_idx <= uop_idx + IDX_W'(1);
            end
            if (latch_total) begin
                uop_last <= ope_last;
                if (ope_bad) begin
                    bad_ope <= 1'b1;
                end
            end
            if (state == S_EIP) begin
                instr_count <= instr_count + COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// tb/tb_cpu_phase_sequencer.sv - self-checking bench for cpu_phase_sequencer

module tb_cpu_phase_sequencer;

    localparam int M = 3;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic        run        = 1'b0;
    logic        halt_req   = 1'b0;
    logic        mem_ready  = 1'b0;
    logic [3:0]  num_of_ope = 4'd0;
`ifdef SINGLE_STEP_EN
    logic        step       = 1'b0;
`endif
    logic        fetch_en;
    logic        decode_en;
    logic [M-1:0] sel_en;
    logic [M-1:0] alu_en;
    logic [M-1:0] wb_en;
    logic        eip_en;
    logic        busy;
    logic        halted;
    logic        bad_ope;
    logic [15:0] instr_count;

    cpu_phase_sequencer #(.MAX_UOPS(M), .COUNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .halt_req    (halt_req),
`ifdef SINGLE_STEP_EN
        .step        (step),
`endif
        .mem_ready   (mem_ready),
        .num_of_ope  (num_of_ope),
        .fetch_en    (fetch_en),
        .decode_en   (decode_en),
        .sel_en      (sel_en),
        .alu_en      (alu_en),
        .wb_en       (wb_en),
        .eip_en      (eip_en),
        .busy        (busy),
        .halted      (halted),
        .bad_ope     (bad_ope),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    // Strobe vector bit positions: fetch 11, decode 10, sel k 7+k, alu k 4+k, wb k 1+k, eip 0.
    localparam int P_FETCH = 11;
    localparam int P_DEC   = 10;
    localparam int P_EIP   = 0;

    logic [11:0] s_vec;
    logic        s_busy, s_halted, s_bad;
    logic [15:0] s_cnt;

    // Reference model: a plan of upcoming strobe positions per instruction.
    int          plan[$];
    bit          m_halted, m_hl, m_bad;
    logic [15:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_instr();
        plan.push_back(P_FETCH);
        plan.push_back(P_DEC);
        plan.push_back(7);
    endtask

    task automatic model_advance();
        bit pend;
        int p;
        int n;
        if (reset) begin
            plan.delete();
            m_halted = 0;
            m_hl     = 0;
            m_bad    = 0;
            m_cnt    = 16'd0;
            return;
        end
        pend = m_hl || halt_req;
        if (halt_req) m_hl = 1;
        if (m_halted) begin
        end else if (plan.size() == 0) begin
            if (pend) m_halted = 1;
            else if (run) start_instr();
        end else begin
            p = plan[0];
            if (!(p == P_FETCH && !mem_ready)) begin
                void'(plan.pop_front());
                if (p == 7) begin
                    n = (num_of_ope == 0) ? 1 : (int'(num_of_ope) > M) ? M : int'(num_of_ope);
                    if (num_of_ope == 0 || int'(num_of_ope) > M) m_bad = 1;
                    plan.push_back(4);
                    plan.push_back(1);
                    for (int k = 1; k < n; k++) begin
                        plan.push_back(7 + k);
                        plan.push_back(4 + k);
                        plan.push_back(1 + k);
                    end
                    plan.push_back(P_EIP);
                end else if (p == P_EIP) begin
                    m_cnt = m_cnt + 16'd1;
                    if (pend) m_halted = 1;
                    else if (run) start_instr();
                end
            end
        end
    endtask

    task automatic tick();
        logic [11:0] ev;
        @(negedge clk);
        s_vec    = {fetch_en, decode_en, sel_en, alu_en, wb_en, eip_en};
        s_busy   = busy;
        s_halted = halted;
        s_bad    = bad_ope;
        s_cnt    = instr_count;
        if (chk_en) begin
            ev = (m_halted || plan.size() == 0) ? 12'd0 : (12'd1 << plan[0]);
            chk("model_strobes", 32'(s_vec), 32'(ev));
            chk("model_busy", 32'(s_busy), 32'(!m_halted && plan.size() != 0));
            chk("model_halted", 32'(s_halted), 32'(m_halted));
            chk("model_bad_ope", 32'(s_bad), 32'(m_bad));
            chk("model_count", 32'(s_cnt), 32'(m_cnt));
            chk("onehot", 32'($countones(s_vec) <= 1), 32'd1);
        end
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        halt_req = 1'b0;
        tick();
        reset    = 1'b0;
    endtask

    typedef struct {
        logic       run;
        logic       halt;
        logic       mem;
        logic [3:0] num;
        int         code;
        logic       busy;
        logic       halted;
        int         cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic h, logic m, logic [3:0] n, int code,
                                logic b, logic hl, int c);
        vec_t v;
        v.run = r; v.halt = h; v.mem = m; v.num = n; v.code = code;
        v.busy = b; v.halted = hl; v.cnt = c;
        return v;
    endfunction

    initial begin
        int lens[$];
        int wbs[$];
        int len;
        int wbc;
        int eips;
        int fetch_after;
        logic [11:0] ev;

        // Table: 1-uop instruction, fetch wait, run dropping mid 3-uop instruction, halt in IDLE.
        tbl.push_back(mk(1, 0, 1, 1, -1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1, 11, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1, 10, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1,  7, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1,  4, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1,  1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1,  0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 3, 11, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 3, 11, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 3, 11, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 3, 11, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 3, 10, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 3,  7, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 3,  4, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 3,  1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 3,  8, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 3,  5, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 3,  2, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 3,  9, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 3,  6, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 3,  3, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 3,  0, 1, 0, 1));
        tbl.push_back(mk(0, 1, 1, 3, -1, 0, 0, 2));
        tbl.push_back(mk(1, 0, 1, 3, -1, 0, 1, 2));
        tbl.push_back(mk(1, 0, 1, 3, -1, 0, 1, 2));

        do_reset();
        chk_en = 1;
        foreach (tbl[i]) begin
            run        = tbl[i].run;
            halt_req   = tbl[i].halt;
            mem_ready  = tbl[i].mem;
            num_of_ope = tbl[i].num;
            tick();
            ev = (tbl[i].code < 0) ? 12'd0 : (12'd1 << tbl[i].code);
            chk($sformatf("tbl%0d_strobes", i), 32'(s_vec), 32'(ev));
            chk($sformatf("tbl%0d_busy", i), 32'(s_busy), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d_halted", i), 32'(s_halted), 32'(tbl[i].halted));
            chk($sformatf("tbl%0d_count", i), 32'(s_cnt), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_bad", i), 32'(s_bad), 32'd0);
        end
        halt_req = 1'b0;

        // Bad counts: 0 runs one uop, 7 runs MAX uops; 3-uop latency 12; bad_ope sticky.
        do_reset();
        chk("reset_bad_ope", 32'(bad_ope), 32'd0);
        run = 1; mem_ready = 1; num_of_ope = 4'd0;
        len = 0; wbc = 0;
        for (int c = 0; c < 60 && lens.size() < 2; c++) begin
            tick();
            if (s_vec != 12'd0) len++;
            if (|s_vec[3:1]) wbc++;
            if (s_vec[0]) begin
                lens.push_back(len);
                wbs.push_back(wbc);
                len = 0; wbc = 0;
                num_of_ope = 4'd7;
            end
        end
        if (lens.size() < 2) begin
            chk("bad_ope_instr_timeout", 32'(lens.size()), 32'd2);
        end else begin
            chk("num0_uops", 32'(wbs[0]), 32'd1);
            chk("num0_len", 32'(lens[0]), 32'd6);
            chk("num7_uops", 32'(wbs[1]), 32'd3);
            chk("num7_len", 32'(lens[1]), 32'd12);
        end
        num_of_ope = 4'd1;
        run = 0;
        for (int c = 0; c < 20; c++) tick();
        chk("bad_ope_sticky", 32'(s_bad), 32'd1);
        do_reset();
        tick();
        chk("bad_ope_cleared", 32'(s_bad), 32'd0);

        // Halt during EXEC of a 2-uop instruction.
        do_reset();
        run = 1; mem_ready = 1; num_of_ope = 4'd2;
        for (int c = 0; c < 4; c++) tick();
        halt_req = 1;
        tick();
        chk("halt_in_exec_alu0", 32'(s_vec), 32'(12'd1 << 4));
        halt_req = 0;
        eips = 0; fetch_after = 0;
        for (int c = 0; c < 20; c++) begin
            run = 1'($urandom_range(0, 1));
            tick();
            if (s_vec[P_FETCH] && eips > 0) fetch_after++;
            if (s_vec[P_EIP]) eips++;
        end
        chk("halt_eip_count", 32'(eips), 32'd1);
        chk("halt_no_fetch", 32'(fetch_after), 32'd0);
        chk("halt_halted", 32'(s_halted), 32'd1);

        // Reset during WB of the second instruction.
        do_reset();
        run = 1; mem_ready = 1; num_of_ope = 4'd1;
        for (int c = 0; c < 11; c++) tick();
        chk("pre_reset_count", 32'(s_cnt), 32'd1);
        reset = 1;
        tick();
        chk("reset_during_wb", 32'(s_vec), 32'(12'd1 << 1));
        reset = 0;
        run = 0;
        tick();
        chk("post_reset_strobes", 32'(s_vec), 32'd0);
        chk("post_reset_count", 32'(s_cnt), 32'd0);
        chk("post_reset_busy", 32'(s_busy), 32'd0);

        // Randomized run against the model.
        for (int c = 0; c < 4000; c++) begin
            reset      = ($urandom_range(0, 299) == 0);
            run        = ($urandom_range(0, 9) != 0);
            halt_req   = ($urandom_range(0, 499) == 0);
            mem_ready  = ($urandom_range(0, 3) != 0);
            num_of_ope = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15))
                                                     : 4'($urandom_range(1, 3));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
